// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locking scheduler sharing one UART transmitter among byte-stream requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic                       clk_50m,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_din,
  output logic                       tx_wr_en,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       tx_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, START_WAIT, DONE_WAIT} state_t;
  state_t        state;
  logic [GW-1:0] last_grant, winner;
  logic          lock, keep;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] timer;
  // winner: the locked owner while it still has data, otherwise the first valid requester after last_grant
  always_comb begin
    winner = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx[GW-1:0]]) winner = idx[GW-1:0];
    end
    if (lock && req_valid[last_grant]) winner = last_grant;
  end
  assign keep = !req_last[winner] && (int'(burst_cnt) + 1 < MAX_BURST);
  // one grant per byte: capture, strobe, wait for busy rise (with timeout), wait for busy fall
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= '0;
      tx_din       <= 8'h00;
      tx_wr_en     <= 1'b0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      tx_err       <= 1'b0;
      last_grant   <= GW'(NUM_REQ - 1);
      lock         <= 1'b0;
      burst_cnt    <= '0;
      timer        <= '0;
    end else begin
      case (state)
        IDLE: if (!tx_busy && |req_valid) begin
          tx_din       <= req_data[{winner, 3'b000} +: 8];
          tx_wr_en     <= 1'b1;
          req_ready    <= NUM_REQ'(1) << winner;
          grant_id     <= winner;
          last_grant   <= winner;
          grant_active <= 1'b1;
          timer        <= '0;
          lock         <= keep;
          burst_cnt    <= keep ? burst_cnt + 1'b1 : '0;
          state        <= LOAD;
        end
        LOAD: begin
          tx_wr_en  <= 1'b0;
          req_ready <= '0;
          state     <= START_WAIT;
        end
        START_WAIT: if (tx_busy) state <= DONE_WAIT;
          else if (timer == TW'(START_TIMEOUT - 1)) begin
            tx_err       <= 1'b1;
            lock         <= 1'b0;
            burst_cnt    <= '0;
            grant_active <= 1'b0;
            state        <= IDLE;
          end else timer <= timer + 1'b1;
        DONE_WAIT: if (!tx_busy) begin
          grant_active <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
